// File: rtl/median_sync_align.sv
// median_sync_align
// Alignment stage between the per-channel median filters and the HDMI transmitter.
// Delays dv/hs/vs and the kernel center pixel by MED_LAT clocks so they line up
// with the median results. Pixels whose 5x5 window reaches outside the frame are
// replaced by the center pixel (BORDER_MODE 0) or by black (BORDER_MODE 1).
// The active frame size is measured for status reporting.
//
// Ports:
//   clk, rst                     pixel clock, synchronous active-high reset
//   in_dv, in_hs, in_vs          timing, sampled as the kernel enters the median units
//   in_center[23:0]              {R,G,B} center pixel of the current kernel
//   med_red/green/blue[7:0]      median results, valid MED_LAT clocks after in_*
//   tx_red/green/blue[7:0]       registered output pixel
//   tx_dv, tx_hs, tx_vs          registered, aligned timing
//   frame_width/height[CNT_W-1:0] last measured active size
//   size_valid                   high once a complete frame has been measured
module median_sync_align #(
  parameter int MED_LAT     = 4,
  parameter int BORDER_MODE = 0,
  parameter int VS_ACTIVE   = 1,
  parameter int CNT_W       = 12
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_dv,
  input  logic             in_hs,
  input  logic             in_vs,
  input  logic [23:0]      in_center,
  input  logic [7:0]       med_red,
  input  logic [7:0]       med_green,
  input  logic [7:0]       med_blue,
  output logic [7:0]       tx_red,
  output logic [7:0]       tx_green,
  output logic [7:0]       tx_blue,
  output logic             tx_dv,
  output logic             tx_hs,
  output logic             tx_vs,
  output logic [CNT_W-1:0] frame_width,
  output logic [CNT_W-1:0] frame_height,
  output logic             size_valid
);

  // Delay-line word: {dv, hs, vs, border, center[23:0]}
  localparam int DW = 28;

  logic [CNT_W-1:0] x;
  logic [CNT_W-1:0] y;
  logic [CNT_W-1:0] shadow;
  logic             prev_dv;
  logic             prev_vs_act;

  logic             vs_act;
  logic             frame_start;
  logic             dv_fall;
  logic             border;
  logic [CNT_W-1:0] y_final;
  logic [CNT_W-1:0] width_src;

  logic [DW-1:0]    dly [MED_LAT];
  logic [DW-1:0]    d;
  logic [23:0]      pix;

  assign vs_act      = (in_vs == (VS_ACTIVE != 0));
  assign frame_start = vs_act && !prev_vs_act;
  assign dv_fall     = prev_dv && !in_dv;
  assign border      = in_dv && ((x < CNT_W'(4)) || (y < CNT_W'(4)));

  // When the frame-start edge coincides with the end of the last line, that line
  // has not been counted into y or latched into the shadow yet, so take it here.
  assign y_final   = (dv_fall && (y != '1)) ? y + 1'b1 : y;
  assign width_src = dv_fall ? x : shadow;

  always_ff @(posedge clk) begin
    if (rst) begin
      x            <= '0;
      y            <= '0;
      shadow       <= '0;
      prev_dv      <= 1'b0;
      prev_vs_act  <= 1'b0;
      frame_width  <= '0;
      frame_height <= '0;
      size_valid   <= 1'b0;
    end else begin
      prev_dv     <= in_dv;
      prev_vs_act <= vs_act;
      if (dv_fall) begin
        shadow <= x;
      end
      if (frame_start) begin
        x <= '0;
        y <= '0;
        if (y_final != '0) begin
          frame_width  <= width_src;
          frame_height <= y_final;
          size_valid   <= 1'b1;
        end
      end else if (dv_fall) begin
        x <= '0;
        if (y != '1) begin
          y <= y + 1'b1;
        end
      end else if (in_dv && (x != '1)) begin
        x <= x + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < MED_LAT; i++) begin
        dly[i] <= '0;
      end
    end else begin
      dly[0] <= {in_dv, in_hs, in_vs, border, in_center};
      for (int unsigned i = 1; i < MED_LAT; i++) begin
        dly[i] <= dly[i-1];
      end
    end
  end

  assign d = dly[MED_LAT-1];

  always_comb begin
    pix = '0;
    if (d[27]) begin
      if (!d[24]) begin
        pix = {med_red, med_green, med_blue};
      end else if (BORDER_MODE == 0) begin
        pix = d[23:0];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      tx_red   <= '0;
      tx_green <= '0;
      tx_blue  <= '0;
      tx_dv    <= 1'b0;
      tx_hs    <= 1'b0;
      tx_vs    <= 1'b0;
    end else begin
      tx_red   <= pix[23:16];
      tx_green <= pix[15:8];
      tx_blue  <= pix[7:0];
      tx_dv    <= d[27];
      tx_hs    <= d[26];
      tx_vs    <= d[25];
    end
  end

endmodule
